ibex_wb_stage_lite: RTL and testbench

Single-entry writeback stage that consumes instructions leaving the execute stage (ALU/multdiv result, or LSU load/store) and retires them. Buffers one instruction, waits for the LSU response where required, drives the register-file write port, and back-pressures the ID/EX pipeline. Sits between the EX block outputs and the register file. Also exposes retire and forwarding information.

---
 rtl/ibex_wb_stage_lite.sv | 117 +++++++++++
 tb/tb_ibex_wb_stage_lite.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_stage_lite.sv
// Single-entry writeback stage: buffers one retiring instruction,
// waits for the LSU response where needed and drives the RF write port.
module ibex_wb_stage_lite #(
  parameter bit          ResetAll = 1'b0,
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_wb_i,
  output logic                ready_wb_o,
  input  logic [1:0]          instr_type_i,
  input  logic                rf_we_i,
  input  logic [4:0]          rf_waddr_i,
  input  logic [31:0]         rf_wdata_i,
  input  logic [31:0]         pc_i,
  input  logic                lsu_resp_valid_i,
  input  logic                lsu_resp_err_i,
  input  logic [31:0]         lsu_rdata_i,
  output logic                rf_we_wb_o,
  output logic [4:0]          rf_waddr_wb_o,
  output logic [31:0]         rf_wdata_wb_o,
  output logic                outstanding_lsu_o,
  output logic                instr_done_o,
  output logic                instr_err_o,
  output logic [31:0]         pc_wb_o,
  output logic                lsu_resp_unexpected_o,
  output logic [CntWidth-1:0] instret_o
);

  typedef enum logic [1:0] {
    WbAlu   = 2'd0,
    WbLoad  = 2'd1,
    WbStore = 2'd2
  } wb_type_e;

  logic                valid_q;
  wb_type_e            type_q;
  wb_type_e            type_d;
  logic                we_q;
  logic [4:0]          waddr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         pc_q;
  logic [CntWidth-1:0] instret_q;

  logic is_alu;
  logic is_load;
  logic done;
  logic accept;
  logic lsu_err;

  // Reserved type code retires like an ALU op
  assign type_d  = (instr_type_i == 2'd3) ? WbAlu
                                         : wb_type_e'(instr_type_i);

  assign is_alu  = (type_q == WbAlu);
  assign is_load = (type_q == WbLoad);
  assign done    = valid_q & (is_alu | lsu_resp_valid_i);
  assign accept  = en_wb_i & ready_wb_o;
  assign lsu_err = done & ~is_alu & lsu_resp_err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      type_q  <= WbAlu;
      we_q    <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      type_q  <= type_d;
      we_q    <= rf_we_i;
    end else if (done) begin
      valid_q <= 1'b0;
    end
  end

  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        waddr_q <= '0;
        wdata_q <= '0;
        pc_q    <= '0;
      end else if (accept) begin
        waddr_q <= rf_waddr_i;
        wdata_q <= rf_wdata_i;
        pc_q    <= pc_i;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      if (accept) begin
        waddr_q <= rf_waddr_i;
        wdata_q <= rf_wdata_i;
        pc_q    <= pc_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
    end else if (done & ~lsu_err) begin
      instret_q <= instret_q + CntWidth'(1);
    end
  end

  assign ready_wb_o            = ~valid_q | done;
  assign rf_we_wb_o            = done & we_q &
                                 (is_alu | (is_load & ~lsu_resp_err_i));
  assign rf_waddr_wb_o         = waddr_q;
  assign rf_wdata_wb_o         = is_load ? lsu_rdata_i : wdata_q;
  assign outstanding_lsu_o     = valid_q & ~is_alu;
  assign instr_done_o          = done;
  assign instr_err_o           = lsu_err;
  assign pc_wb_o               = pc_q;
  assign lsu_resp_unexpected_o = lsu_resp_valid_i & (~valid_q | is_alu);
  assign instret_o             = instret_q;

endmodule

// File: tb/tb_ibex_wb_stage_lite.sv
// Scoreboard bench for ibex_wb_stage_lite: directed head, random tail,
// reset during an outstanding load; a 2-bit counter copy checks wrap.
module tb_ibex_wb_stage_lite;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_wb_i = 1'b0;
  logic [1:0]  instr_type_i = '0;
  logic        rf_we_i = 1'b0;
  logic [4:0]  rf_waddr_i = '0;
  logic [31:0] rf_wdata_i = '0;
  logic [31:0] pc_i = '0;
  logic        lsu_resp_valid_i = 1'b0;
  logic        lsu_resp_err_i = 1'b0;
  logic [31:0] lsu_rdata_i = '0;

  logic        ready_wb_o, rf_we_wb_o, outstanding_lsu_o;
  logic        instr_done_o, instr_err_o, lsu_resp_unexpected_o;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o, pc_wb_o, instret_o;

  logic        ready_2, we_2, outst_2, done_2, err_2, unexp_2;
  logic [4:0]  waddr_2;
  logic [31:0] wdata_2, pc_2;
  logic [1:0]  instret_2;

  always #5 clk = ~clk;

  ibex_wb_stage_lite #(.ResetAll(1'b1), .CntWidth(32)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_wb_i(en_wb_i),
    .ready_wb_o(ready_wb_o), .instr_type_i(instr_type_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
    .rf_wdata_i(rf_wdata_i), .pc_i(pc_i),
    .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_resp_err_i(lsu_resp_err_i), .lsu_rdata_i(lsu_rdata_i),
    .rf_we_wb_o(rf_we_wb_o), .rf_waddr_wb_o(rf_waddr_wb_o),
    .rf_wdata_wb_o(rf_wdata_wb_o),
    .outstanding_lsu_o(outstanding_lsu_o),
    .instr_done_o(instr_done_o), .instr_err_o(instr_err_o),
    .pc_wb_o(pc_wb_o),
    .lsu_resp_unexpected_o(lsu_resp_unexpected_o),
    .instret_o(instret_o)
  );

  ibex_wb_stage_lite #(.ResetAll(1'b0), .CntWidth(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .en_wb_i(en_wb_i),
    .ready_wb_o(ready_2), .instr_type_i(instr_type_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
    .rf_wdata_i(rf_wdata_i), .pc_i(pc_i),
    .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_resp_err_i(lsu_resp_err_i), .lsu_rdata_i(lsu_rdata_i),
    .rf_we_wb_o(we_2), .rf_waddr_wb_o(waddr_2),
    .rf_wdata_wb_o(wdata_2), .outstanding_lsu_o(outst_2),
    .instr_done_o(done_2), .instr_err_o(err_2), .pc_wb_o(pc_2),
    .lsu_resp_unexpected_o(unexp_2), .instret_o(instret_2)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  bit   unexp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: retire records and unexpected-response flags
  initial begin
    longint unsigned cnt;
    exp_t e;
    bit   eu;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        cnt = 0;
        exp_q.delete();
        unexp_q.delete();
        continue;
      end
      chk("instret", instret_o, cnt & 64'hFFFF_FFFF);
      chk("instret_wrap2", instret_2, cnt % 4);
      eu = 1'b0;
      if (unexp_q.size() > 0) eu = unexp_q.pop_front();
      chk("unexpected", lsu_resp_unexpected_o, eu);
      if (instr_done_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done: got retire expected none");
        end else begin
          e = exp_q.pop_front();
          chk("rf_we", rf_we_wb_o, e.we);
          chk("waddr", rf_waddr_wb_o, e.waddr);
          if (e.we) chk("wdata", rf_wdata_wb_o, e.wdata);
          chk("instr_err", instr_err_o, e.err);
          chk("pc", pc_wb_o, e.pc);
          if (!e.err) cnt++;
        end
      end else begin
        chk("idle_we", rf_we_wb_o, 1'b0);
      end
    end
  end

  // Driver plus a transaction-level model of the single buffer entry
  initial begin
    int          cyc;
    int          issued;
    int          lsu_wait;
    int          o_delay;
    bit          busy, busy_alu, offering;
    bit          resp, stray, exp_ready;
    logic [1:0]  o_type;
    logic        o_we, o_err, h_err;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata, o_pc, o_rdata, h_rdata;
    exp_t        r;
    localparam int N = 80;

    issued = 0; lsu_wait = 0; o_delay = 0;
    busy = 0; busy_alu = 0; offering = 0;
    o_type = '0; o_we = 0; o_err = 0; h_err = 0;
    o_waddr = '0; o_wdata = '0; o_pc = '0;
    o_rdata = '0; h_rdata = '0;

    #2;
    chk("rst_ready", ready_wb_o, 1'b1);
    chk("rst_done", instr_done_o, 1'b0);
    chk("rst_we", rf_we_wb_o, 1'b0);
    chk("rst_wdata", rf_wdata_wb_o, 32'h0);
    chk("rst_pc", pc_wb_o, 32'h0);
    chk("rst_outst", outstanding_lsu_o, 1'b0);
    chk("rst_instret", instret_o, 32'h0);

    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    for (cyc = 0; cyc < 4000; cyc++) begin
      resp  = busy && !busy_alu && lsu_wait == 0;
      stray = !resp && !(busy && !busy_alu) && issued >= 6 &&
              ($urandom % 8 == 0);
      lsu_resp_valid_i = resp | stray;
      lsu_resp_err_i   = resp ? h_err : 1'($urandom % 2);
      lsu_rdata_i      = resp ? h_rdata : $urandom;
      if (stray) unexp_q.push_back(1'b1);

      if (!offering && issued < N &&
          (issued < 6 || $urandom % 4 != 0)) begin
        o_type  = 2'($urandom % 4);
        o_we    = 1'($urandom % 2);
        o_waddr = 5'($urandom);
        o_wdata = $urandom;
        o_pc    = $urandom;
        o_delay = int'($urandom % 5);
        o_err   = ($urandom % 4 == 0);
        o_rdata = $urandom;
        if (issued == 0) begin
          o_type = 2'd0; o_we = 1; o_waddr = 5'd5;
          o_wdata = 32'hDEADBEEF;
        end else if (issued <= 3) begin
          o_type = 2'd0; o_we = 1;
        end else if (issued == 4) begin
          o_type = 2'd1; o_we = 1; o_waddr = 5'd7;
          o_rdata = 32'h12345678; o_delay = 3; o_err = 0;
        end else if (issued == 5) begin
          o_type = 2'd2; o_delay = 1; o_err = 1;
        end
        offering = 1;
        issued++;
      end
      en_wb_i      = offering;
      instr_type_i = o_type;
      rf_we_i      = o_we;
      rf_waddr_i   = o_waddr;
      rf_wdata_i   = o_wdata;
      pc_i         = o_pc;

      exp_ready = !busy || busy_alu || resp;
      @(negedge clk);
      chk("ready", ready_wb_o, exp_ready);
      chk("outstanding", outstanding_lsu_o, busy && !busy_alu);

      @(posedge clk);
      if (busy && (busy_alu || resp)) busy = 0;
      else if (busy) lsu_wait--;
      if (offering && exp_ready) begin
        busy     = 1;
        busy_alu = (o_type == 2'd0 || o_type == 2'd3);
        lsu_wait = o_delay;
        h_err    = o_err;
        h_rdata  = o_rdata;
        r.waddr  = o_waddr;
        r.pc     = o_pc;
        r.wdata  = o_wdata;
        if (busy_alu) begin
          r.we = o_we; r.err = 0;
        end else if (o_type == 2'd1) begin
          r.we = o_we & ~o_err; r.err = o_err; r.wdata = o_rdata;
        end else begin
          r.we = 0; r.err = o_err;
        end
        exp_q.push_back(r);
        offering = 0;
      end
      #1;
      if (issued >= N && !offering && !busy) break;
    end
    en_wb_i = 0;
    lsu_resp_valid_i = 0;
    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL timeout: got %0d cycles expected < 4000", cyc);
    end
    @(negedge clk);
    chk("drained", exp_q.size(), 0);

    // Reset while a load is outstanding
    @(posedge clk); #1;
    en_wb_i = 1; instr_type_i = 2'd1; rf_we_i = 1;
    rf_waddr_i = 5'd9; rf_wdata_i = 32'h55; pc_i = 32'h100;
    @(posedge clk); #1;
    en_wb_i = 0;
    @(negedge clk);
    chk("load_outst", outstanding_lsu_o, 1'b1);
    chk("load_stall", ready_wb_o, 1'b0);
    @(posedge clk); #1;
    rst_ni = 0;
    #1;
    chk("arst_ready", ready_wb_o, 1'b1);
    chk("arst_outst", outstanding_lsu_o, 1'b0);
    chk("arst_we", rf_we_wb_o, 1'b0);
    chk("arst_waddr", rf_waddr_wb_o, 5'd0);
    chk("arst_pc", pc_wb_o, 32'h0);
    chk("arst_instret", instret_o, 32'h0);
    chk("arst_instret2", instret_2, 2'd0);
    @(posedge clk); #1;
    rst_ni = 1;
    lsu_resp_valid_i = 1; lsu_rdata_i = 32'hCAFE; lsu_resp_err_i = 0;
    unexp_q.push_back(1'b1);
    @(negedge clk);
    chk("stale_no_done", instr_done_o, 1'b0);
    @(posedge clk); #1;
    lsu_resp_valid_i = 0;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
